// File: rtl/fifo_sync_param_if.sv
// fifo_if: handshake/data bundle between a FIFO and its user.
//   master : user side (drives wr_en, rd_en, data_in)
//   slave  : FIFO side (drives data_out, status flags, pulses, count)
interface fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds and an occupancy count.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - fifo_if.slave: wr_en/rd_en/data_in in; data_out, wr_ack,
//            overflow, underflow (registered one-cycle pulses), full, empty,
//            almostfull, almostempty, count (combinational from count) out.
//
// Build option: define FIFO_FWFT_EN for first-word fall-through
// (data_out shows the head word combinationally, 0 when empty).
// Default build: data_out is registered, valid one cycle after a read.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  fifo_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "fifo_sync_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $fatal(1, "fifo_sync_param: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "fifo_sync_param: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty;
  logic          do_wr, do_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    // At full a simultaneous read frees the slot the write lands in.
    do_wr = bus.wr_en && (!full || bus.rd_en);
    do_rd = bus.rd_en && !empty;

    wr_ptr_d    = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ack_d    = do_wr;
    overflow_d  = bus.wr_en && !do_wr;
    underflow_d = bus.rd_en && empty;

    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; the write is suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : mem[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (do_rd) begin
      data_out_d = mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= CW'(AFULL_TH));
  assign bus.almostempty = !empty && (count_q <= CW'(AEMPTY_TH));
  assign bus.count       = count_q;

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's fixed-size FIFO DUT.
- Adds programmable almost-full and almost-empty thresholds, an occupancy count output and defined simultaneous read/write semantics at full and empty.
- Single clock domain, sits behind fifo_if in the FIFO verification environment.
- Optional first-word-fall-through read mode.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- DEPTH, 8, number of entries; any integer >= 2, not required to be a power of two.
- AFULL_TH, DEPTH-2, almostfull asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almostempty asserts when 1 <= count <= AEMPTY_TH; legal range 0..DEPTH-1.
- Illegal parameter values: elaboration-time $fatal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected.
- underflow  output  1  registered; previous-cycle read rejected.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almostfull  output  1  count >= AFULL_TH.
- almostempty  output  1  count != 0 and count <= AEMPTY_TH.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset: one clock domain only. rst_n is synchronous and active-low, sampled on rising clk.
- Values while rst_n=0 at an edge:
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0.
  - wr_ack, overflow, underflow = 0.
  - Consequently empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not cleared.
- Reset mid-operation: all stored data is discarded and wr_en/rd_en are ignored on that edge.
- Status flags are combinational from count; there is zero latency after the edge that changes count.
- Write, when wr_en=1 and (!full or rd_en=1):
  - mem[wr_ptr] <= data_in.
  - wr_ptr advances; it wraps from DEPTH-1 to 0.
  - wr_ack=1 for the next cycle.
- Rejected write, when wr_en=1, full=1 and rd_en=0: overflow=1 for the next cycle; no state change.
- Read, default mode, when rd_en=1 and !empty:
  - data_out <= mem[rd_ptr] on that edge, so data is valid one cycle after rd_en.
  - rd_ptr advances and wraps at DEPTH-1.
- Rejected read, when rd_en=1 and empty=1: underflow=1 for the next cycle; data_out holds its last value.
- Simultaneous write and read:
  - Neither full nor empty: both performed; count unchanged.
  - full=1: both performed; the write lands in the slot freed this cycle; no overflow; count stays DEPTH.
  - empty=1: only the write is performed; underflow=1; count becomes 1.
- Count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0.
- wr_ack, overflow and underflow are single-cycle pulses; they deassert the following cycle unless re-triggered.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = empty ? 0 : mem[rd_ptr], combinational.
  - The head word is visible without a read; rd_en pops it and the next word appears the same cycle.
  - Underflow, full/empty and count rules are unchanged.
- Undefined: registered read with one-cycle latency, as specified above.

Test Plan (DATA_WIDTH=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2):
- Fill: 9 consecutive writes of 0xA000+i, rd_en=0.
  - wr_ack after each of writes 1-8.
  - almostfull from count=6.
  - full at count=8.
  - Write 9 gives overflow=1 for one cycle; count stays 8.
- Drain: 9 consecutive reads.
  - data_out = 0xA000..0xA007 in order, each one cycle after its rd_en.
  - almostempty at count 2 and 1.
  - empty at count 0.
  - Read 9 gives underflow=1; data_out holds 0xA007.
- Simultaneous at boundaries:
  - At full, wr_en=rd_en=1 with data 0xBEEF: count stays 8, no overflow, 0xBEEF is read last.
  - At empty, wr_en=rd_en=1: count=1, underflow=1, later read returns the written word.
- Wrap-around: 20 interleaved write/read pairs (2 writes, 1 read pattern) up to full, then drain.
  - All words are returned in order across pointer wrap.
  - count matches the reference model every cycle.
- Reset mid-operation: with count=5, rst_n=0 for one edge.
  - Next cycle: count=0, empty=1, data_out=0, all pulses 0.
  - A subsequent write/read returns only post-reset data.
- FWFT build (FIFO_FWFT_EN):
  - Write 0x1111 then 0x2222: data_out=0x1111 the cycle after the first write with no read.
  - rd_en=1 shows 0x2222 immediately after that edge.
  - Second pop gives data_out=0 and empty=1.
